monobit_seq: RTL and testbench

Block-level sequencer for the monobit (frequency) randomness test in `tt_um_monobit`. It accepts a serial bit stream, splits it into `num_blk` blocks of `blk_len` bits, and keeps a signed ones-minus-zeros sum per block. At the end of each block it compares |S| against a threshold and counts failing blocks. It reports one pass/fail verdict per run. It sits between the `ui_in` bit capture logic and the `uo_out` status mapping.

---
 rtl/monobit_seq_if.sv | 30 +++
 rtl/monobit_seq.sv | 208 ++++++++++++++++++++
 tb/tb_monobit_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monobit_seq_if.sv
// monobit_seq_if
//   Serial bit-stream channel feeding the monobit sequencer.
//
//   Handshake: the producer (master) drives bit_in/bit_valid, the consumer
//   (slave) drives bit_ready. A bit transfers on a rising clock edge where
//   bit_valid and bit_ready are both high. bit_valid while bit_ready is low
//   is simply dropped; the producer may change bit_in freely at any time and
//   is not required to hold an offer that was not taken.
//
//   Signals:
//     bit_in    master -> slave  data bit
//     bit_valid master -> slave  bit_in is valid this cycle
//     bit_ready slave  -> master consumer can take a bit this cycle
interface monobit_seq_if;
   logic bit_in;
   logic bit_valid;
   logic bit_ready;

   modport master (
      output bit_in,
      output bit_valid,
      input  bit_ready
   );

   modport slave (
      input  bit_in,
      input  bit_valid,
      output bit_ready
   );
endinterface

// File: rtl/monobit_seq.sv
// monobit_seq
//   Block-level sequencer for the monobit (frequency) randomness test.
//   A run is num_blk blocks of blk_len bits. Each block keeps a signed
//   ones-minus-zeros sum S; at the end of a block |S| is compared against
//   thr and failing blocks are counted. One pass/fail verdict per run.
//
//   Optional feature (macro MONOBIT_SEQ_CONT_EN): adds input `cont`. When
//   high during DONE the run restarts immediately with the same latched
//   configuration instead of returning to IDLE.
//
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     start       one-cycle run request, accepted only in IDLE
//     blk_len     bits per block      (latched at accepted start)
//     num_blk     blocks per run      (latched at accepted start)
//     thr         pass threshold, block passes if |S| <= thr (latched)
//     cont        (MONOBIT_SEQ_CONT_EN only) chain another run at DONE
//     bit_if      slave side of the bit stream (bit_in/bit_valid/bit_ready)
//     busy        state is not IDLE
//     blk_done    one-cycle pulse per completed block
//     last_abs    |S| of the most recently completed block
//     blk_fail    most recently completed block failed
//     fail_cnt    failed blocks in the current or last run
//     done        one-cycle pulse at the end of a run
//     pass        fail_cnt == 0, updated at done, cleared at accepted start
//     cfg_err     one-cycle pulse (cycle after) when start is rejected
//     state_dbg   current FSM state, for debug/checkers
module monobit_seq #(
   parameter int LEN_W  = 8,
   parameter int NBLK_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  blk_len,
   input  logic [NBLK_W-1:0] num_blk,
   input  logic [LEN_W-1:0]  thr,
`ifdef MONOBIT_SEQ_CONT_EN
   input  logic              cont,
`endif
   monobit_seq_if.slave      bit_if,
   output logic              busy,
   output logic              blk_done,
   output logic [LEN_W-1:0]  last_abs,
   output logic              blk_fail,
   output logic [NBLK_W-1:0] fail_cnt,
   output logic              done,
   output logic              pass,
   output logic              cfg_err,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_EVAL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [NBLK_W-1:0]   nblk_q, nblk_d;
   logic [LEN_W-1:0]    thr_q, thr_d;
   // One bit wider than the block length so +/-blk_len always fits.
   logic [LEN_W:0]      sum_q, sum_d;
   logic [LEN_W-1:0]    bcnt_q, bcnt_d;
   logic [NBLK_W-1:0]   bidx_q, bidx_d;
   logic [LEN_W-1:0]    last_abs_q, last_abs_d;
   logic                blk_fail_q, blk_fail_d;
   logic [NBLK_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic                pass_q, pass_d;
   logic                blk_done_q, blk_done_d;
   logic                cfg_err_q, cfg_err_d;

   logic                xfer;
   logic [LEN_W-1:0]    abs_val;
   logic                fail_now;
   logic [LEN_W-1:0]    bcnt_inc;
   logic [NBLK_W-1:0]   bidx_inc;

   localparam logic [LEN_W:0] SUM_ONE = {{LEN_W{1'b0}}, 1'b1};

   assign xfer     = bit_if.bit_valid && (state_q == S_RUN);
   // |S| never exceeds blk_len, so the magnitude fits in LEN_W bits and
   // only the low bits of the negation are needed.
   assign abs_val  = sum_q[LEN_W] ? (~sum_q[LEN_W-1:0] + 1'b1) : sum_q[LEN_W-1:0];
   assign fail_now = (abs_val > thr_q);
   assign bcnt_inc = bcnt_q + 1'b1;
   assign bidx_inc = bidx_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      nblk_d     = nblk_q;
      thr_d      = thr_q;
      sum_d      = sum_q;
      bcnt_d     = bcnt_q;
      bidx_d     = bidx_q;
      last_abs_d = last_abs_q;
      blk_fail_d = blk_fail_q;
      fail_cnt_d = fail_cnt_q;
      pass_d     = pass_q;
      blk_done_d = 1'b0;
      cfg_err_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((blk_len == '0) || (num_blk == '0)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  len_d      = blk_len;
                  nblk_d     = num_blk;
                  thr_d      = thr;
                  sum_d      = '0;
                  bcnt_d     = '0;
                  bidx_d     = '0;
                  fail_cnt_d = '0;
                  pass_d     = 1'b0;
                  blk_fail_d = 1'b0;
                  state_d    = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (xfer) begin
               sum_d  = bit_if.bit_in ? (sum_q + SUM_ONE) : (sum_q - SUM_ONE);
               bcnt_d = bcnt_inc;
               if (bcnt_inc == len_q) begin
                  state_d = S_EVAL;
               end
            end
         end

         S_EVAL: begin
            last_abs_d = abs_val;
            blk_fail_d = fail_now;
            fail_cnt_d = fail_cnt_q + {{(NBLK_W-1){1'b0}}, fail_now};
            blk_done_d = 1'b1;
            sum_d      = '0;
            bcnt_d     = '0;
            bidx_d     = bidx_inc;
            state_d    = (bidx_inc == nblk_q) ? S_DONE : S_RUN;
         end

         S_DONE: begin
            pass_d  = (fail_cnt_q == '0);
            state_d = S_IDLE;
`ifdef MONOBIT_SEQ_CONT_EN
            if (cont) begin
               fail_cnt_d = '0;
               bidx_d     = '0;
               state_d    = S_RUN;
            end
`endif
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         nblk_q     <= '0;
         thr_q      <= '0;
         sum_q      <= '0;
         bcnt_q     <= '0;
         bidx_q     <= '0;
         last_abs_q <= '0;
         blk_fail_q <= 1'b0;
         fail_cnt_q <= '0;
         pass_q     <= 1'b0;
         blk_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         nblk_q     <= nblk_d;
         thr_q      <= thr_d;
         sum_q      <= sum_d;
         bcnt_q     <= bcnt_d;
         bidx_q     <= bidx_d;
         last_abs_q <= last_abs_d;
         blk_fail_q <= blk_fail_d;
         fail_cnt_q <= fail_cnt_d;
         pass_q     <= pass_d;
         blk_done_q <= blk_done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign bit_if.bit_ready = (state_q == S_RUN);
   assign busy             = (state_q != S_IDLE);
   // done is the DONE state itself, which lands in the same cycle as the
   // final blk_done pulse.
   assign done             = (state_q == S_DONE);
   assign blk_done         = blk_done_q;
   assign last_abs         = last_abs_q;
   assign blk_fail         = blk_fail_q;
   assign fail_cnt         = fail_cnt_q;
   assign pass             = pass_q;
   assign cfg_err          = cfg_err_q;
   assign state_dbg        = state_q;

endmodule

// File: tb/tb_monobit_seq.sv
// tb_monobit_seq
//   Directed and randomized bench for monobit_seq. Expected block results
//   come from a per-block ones/zeros count model; a negedge monitor checks
//   every blk_done/done pulse against the expected queues.
module tb_monobit_seq;
   localparam int LEN_W  = 8;
   localparam int NBLK_W = 4;

   typedef bit bitq_t[$];

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  blk_len;
   logic [NBLK_W-1:0] num_blk;
   logic [LEN_W-1:0]  thr;
   logic              busy;
   logic              blk_done;
   logic [LEN_W-1:0]  last_abs;
   logic              blk_fail;
   logic [NBLK_W-1:0] fail_cnt;
   logic              done;
   logic              pass;
   logic              cfg_err;
   logic [1:0]        state_dbg;
`ifdef MONOBIT_SEQ_CONT_EN
   logic              cont;
`endif

   monobit_seq_if bif ();

   monobit_seq #(.LEN_W(LEN_W), .NBLK_W(NBLK_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .blk_len   (blk_len),
      .num_blk   (num_blk),
      .thr       (thr),
`ifdef MONOBIT_SEQ_CONT_EN
      .cont      (cont),
`endif
      .bit_if    (bif.slave),
      .busy      (busy),
      .blk_done  (blk_done),
      .last_abs  (last_abs),
      .blk_fail  (blk_fail),
      .fail_cnt  (fail_cnt),
      .done      (done),
      .pass      (pass),
      .cfg_err   (cfg_err),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic [LEN_W-1:0]  exp_abs_q[$];
   logic              exp_fail_q[$];
   logic [NBLK_W-1:0] exp_cnt_q[$];
   logic              exp_pass_q[$];
   bit                pend_pass = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: each block's S is (ones - zeros) = 2*ones - len.
   task automatic model(input int len, input int nb, input int th, input bitq_t bits);
      int fc = 0;
      for (int b = 0; b < nb; b++) begin
         int ones = 0;
         int s;
         int a;
         bit f;
         for (int k = 0; k < len; k++) ones += int'(bits[b*len + k]);
         s = 2*ones - len;
         a = (s < 0) ? -s : s;
         f = (a > th);
         fc += int'(f);
         exp_abs_q.push_back(LEN_W'(a));
         exp_fail_q.push_back(f);
         exp_cnt_q.push_back(NBLK_W'(fc));
      end
      exp_pass_q.push_back(fc == 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         pend_pass = 1'b0;
      end else begin
         if (pend_pass) begin
            pend_pass = 1'b0;
            if (exp_pass_q.size() != 0) check("pass", pass, exp_pass_q.pop_front());
         end
         if (done) begin
            check("done_expected", exp_pass_q.size() != 0, 1);
            pend_pass = 1'b1;
         end
         if (blk_done) begin
            check("blk_done_expected", exp_abs_q.size() != 0, 1);
            if (exp_abs_q.size() != 0) begin
               check("last_abs", last_abs, exp_abs_q.pop_front());
               check("blk_fail", blk_fail, exp_fail_q.pop_front());
               check("fail_cnt", fail_cnt, exp_cnt_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic bitq_t mk(input string s);
      bitq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
      return q;
   endfunction

   function automatic bitq_t rnd_bits(input int n, input int mode);
      bitq_t q;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       q.push_back(1'b0);
            1:       q.push_back(1'b1);
            default: q.push_back(1'($urandom_range(0, 1)));
         endcase
      end
      return q;
   endfunction

   task automatic do_start(input int len, input int nb, input int th, input bit expect_ok);
      @(negedge clk);
      start   = 1'b1;
      blk_len = LEN_W'(len);
      num_blk = NBLK_W'(nb);
      thr     = LEN_W'(th);
      @(negedge clk);
      start = 1'b0;
      if (expect_ok) begin
         check("start_busy", busy, 1);
         check("start_ready", bif.bit_ready, 1);
         check("start_pass_clr", pass, 0);
         check("start_fcnt_clr", fail_cnt, 0);
         check("start_bfail_clr", blk_fail, 0);
         check("start_no_cfg_err", cfg_err, 0);
      end else begin
         check("cfg_err_pulse", cfg_err, 1);
         check("cfg_err_busy", busy, 0);
         @(negedge clk);
         check("cfg_err_one_cycle", cfg_err, 0);
         check("cfg_err_busy2", busy, 0);
      end
   endtask

   // Offers the bits in order; with gaps, bit_valid is randomly withheld.
   // While bit_ready is low the bus carries junk (valid in gap mode) which
   // must be dropped. Returns the cycle of the last transfer and how many
   // not-ready cycles were seen.
   task automatic send_bits(input bitq_t bits, input bit gaps, output int last_cyc, output int low_cnt);
      int i = 0;
      int guard = 0;
      last_cyc = 0;
      low_cnt  = 0;
      while (i < bits.size() && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (!bif.bit_ready) begin
            low_cnt++;
            bif.bit_valid = gaps;
            bif.bit_in    = 1'($urandom_range(0, 1));
         end else if (gaps && $urandom_range(0, 2) != 0) begin
            bif.bit_valid = 1'b0;
            bif.bit_in    = 1'($urandom_range(0, 1));
         end else begin
            bif.bit_valid = 1'b1;
            bif.bit_in    = bits[i];
            i++;
            last_cyc = cyc;
         end
      end
      check("bits_sent", i, bits.size());
   endtask

   task automatic finish_run(input int last_cyc, input bit gaps);
      int g = 0;
      do begin
         @(negedge clk);
         bif.bit_valid = gaps;
         bif.bit_in    = 1'($urandom_range(0, 1));
         g++;
      end while (!done && g < 20);
      check("done_latency", cyc - last_cyc, 2);
      @(negedge clk);
      bif.bit_valid = 1'b0;
      check("busy_after_done", busy, 0);
      check("ready_after_done", bif.bit_ready, 0);
      check("done_one_cycle", done, 0);
   endtask

   task automatic run_cfg(input int len, input int nb, input int th, input bitq_t bits, input bit gaps);
      int last_cyc;
      int low_cnt;
      model(len, nb, th, bits);
      do_start(len, nb, th, 1'b1);
      send_bits(bits, gaps, last_cyc, low_cnt);
      check("ready_low_boundaries", low_cnt, nb - 1);
      finish_run(last_cyc, gaps);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int    last_cyc;
      int    low_cnt;
      bitq_t b;

      rst           = 1'b1;
      start         = 1'b0;
      blk_len       = '0;
      num_blk       = '0;
      thr           = '0;
      bif.bit_in    = 1'b0;
      bif.bit_valid = 1'b0;
`ifdef MONOBIT_SEQ_CONT_EN
      cont          = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_ready", bif.bit_ready, 0);
      check("rst_last_abs", last_abs, 0);
      check("rst_fail_cnt", fail_cnt, 0);
      check("rst_pass", pass, 0);
      check("rst_done", done, 0);

      // Test 1: |S| == thr is a pass.
      run_cfg(8, 1, 2, mk("11111000"), 1'b0);
      check("t1_last_abs", last_abs, 2);
      check("t1_blk_fail", blk_fail, 0);
      check("t1_pass", pass, 1);

      // Test 2: all ones, with a start poked mid-run that must be ignored.
      b = mk("11111111");
      model(8, 1, 4, b);
      do_start(8, 1, 4, 1'b1);
      send_bits(b[0:2], 1'b0, last_cyc, low_cnt);
      @(negedge clk);
      bif.bit_valid = 1'b0;
      start   = 1'b1;
      blk_len = '0;
      num_blk = '0;
      @(negedge clk);
      start = 1'b0;
      check("midrun_no_cfg_err", cfg_err, 0);
      check("midrun_busy", busy, 1);
      send_bits(b[3:7], 1'b0, last_cyc, low_cnt);
      finish_run(last_cyc, 1'b0);
      check("t2_last_abs", last_abs, 8);
      check("t2_blk_fail", blk_fail, 1);
      check("t2_fail_cnt", fail_cnt, 1);
      check("t2_pass", pass, 0);

      // Test 5: reset after 5 bits of a block.
      do_start(8, 1, 2, 1'b1);
      send_bits(mk("11111"), 1'b0, last_cyc, low_cnt);
      @(negedge clk);
      bif.bit_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", busy, 0);
      check("mrst_ready", bif.bit_ready, 0);
      check("mrst_last_abs", last_abs, 0);
      check("mrst_blk_fail", blk_fail, 0);
      check("mrst_fail_cnt", fail_cnt, 0);
      check("mrst_blk_done", blk_done, 0);
      check("mrst_done", done, 0);
      check("mrst_pass", pass, 0);
      check("mrst_cfg_err", cfg_err, 0);
      run_cfg(8, 1, 2, mk("11111000"), 1'b0);
      check("t5_last_abs", last_abs, 2);
      check("t5_pass", pass, 1);

      // Test 3: three blocks, one failing.
      run_cfg(4, 3, 1, mk("101011110110"), 1'b0);
      check("t3_last_abs", last_abs, 0);
      check("t3_fail_cnt", fail_cnt, 1);
      check("t3_pass", pass, 0);

      // Test 4: rejected configurations.
      do_start(0, 1, 2, 1'b0);
      do_start(8, 0, 2, 1'b0);

      // Test 6: sparse bit_valid, offers during EVAL/DONE dropped.
      run_cfg(8, 1, 2, mk("11111000"), 1'b1);
      check("t6_last_abs", last_abs, 2);
      check("t6_pass", pass, 1);

      // Maximum block length boundaries.
      run_cfg(255, 1, 254, rnd_bits(255, 1), 1'b0);
      check("max_len_abs", last_abs, 255);
      run_cfg(255, 1, 255, rnd_bits(255, 0), 1'b0);
      check("max_len_pass", pass, 1);

      // Randomized runs.
      for (int r = 0; r < 10; r++) begin
         int len;
         int nb;
         int th;
         len = $urandom_range(1, 16);
         nb  = $urandom_range(1, 5);
         th  = $urandom_range(0, len);
         run_cfg(len, nb, th, rnd_bits(len*nb, 2), 1'($urandom_range(0, 1)));
      end

`ifdef MONOBIT_SEQ_CONT_EN
      // Two chained runs: two done pulses, busy never drops between them.
      begin
         bitq_t b1;
         bitq_t b2;
         int    g;
         b1 = mk("1111");
         b2 = mk("1001");
         model(4, 1, 1, b1);
         model(4, 1, 1, b2);
         cont = 1'b1;
         do_start(4, 1, 1, 1'b1);
         send_bits(b1, 1'b0, last_cyc, low_cnt);
         g = 0;
         do begin
            @(negedge clk);
            bif.bit_valid = 1'b0;
            g++;
         end while (!done && g < 20);
         check("cont_done1_latency", cyc - last_cyc, 2);
         @(negedge clk);
         cont = 1'b0;
         check("cont_busy_held", busy, 1);
         check("cont_ready", bif.bit_ready, 1);
         check("cont_fcnt_clr", fail_cnt, 0);
         send_bits(b2, 1'b0, last_cyc, low_cnt);
         finish_run(last_cyc, 1'b0);
      end
`endif

      repeat (3) @(negedge clk);
      check("exp_queues_drained", exp_abs_q.size() + exp_pass_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
